if_fetch2: RTL and testbench

Two-wide instruction fetch stage that sits directly upstream of the IF/ID circular-buffer stage. Each cycle it presents an 8-byte-aligned fetch address to the instruction cache, splits the returned 64-bit word into up to two 32-bit instructions, and pushes them with their next-PC values into the IF/ID buffer. It respects the buffer's fullness and handles cache misses and execute-stage branch redirects.

---
 rtl/if_fetch2.sv | 131 +++++++++++++
 tb/tb_if_fetch2.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/if_fetch2.sv
// if_fetch2: two-wide instruction fetch stage feeding the IF/ID circular buffer.
// It presents an 8-byte-aligned address to the I-cache and splits the returned
// 64-bit word into up to two instructions. The IF/ID write count follows the
// buffer's full/almost-full signals. Execute-stage redirects take priority.
// Optional feature: define IF_PERF_CNT_EN to build the fetched/stall counters.
// When it is not defined, both perf ports are tied to zero.

`ifndef NOOP_INST
`define NOOP_INST 32'h47ff041f
`endif

module if_fetch2 #(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_enable,
    input  logic        ex_take_branch,
    input  logic [63:0] ex_target_pc,
    input  logic [63:0] Icache2proc_data,
    input  logic        Icache2proc_valid,
    input  logic        ifid_full,
    input  logic        ifid_full_almost,
    output logic [63:0] proc2Icache_addr,
    output logic [63:0] if_NPC_out1,
    output logic [63:0] if_NPC_out2,
    output logic [31:0] if_IR_out1,
    output logic [31:0] if_IR_out2,
    output logic        if_valid_inst_out1,
    output logic        if_valid_inst_out2,
    output logic        din1_en,
    output logic        din2_en,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall
);

    typedef enum logic {FETCH, MISS} state_t;

    logic [63:0] pc;
    state_t      state, state_nx;
    logic [1:0]  n;

    assign proc2Icache_addr = {pc[63:3], 3'b000};

    // Write count into IF/ID. The guards are in priority order, and full beats almost-full.
    always_comb begin
        n = 2'd2;
        if (reset || !if_enable || ex_take_branch || !Icache2proc_valid || ifid_full)
            n = 2'd0;
        else if (ifid_full_almost || pc[2])
            n = 2'd1;
    end

    // Slot formation. An odd-word PC only has its upper word left in the line.
    always_comb begin
        din1_en            = (n != 2'd0);
        din2_en            = (n == 2'd2);
        if_valid_inst_out1 = din1_en;
        if_valid_inst_out2 = din2_en;
        if_IR_out1         = `NOOP_INST;
        if_IR_out2         = `NOOP_INST;
        if_NPC_out1        = 64'h0;
        if_NPC_out2        = 64'h0;
        if (!reset) begin
            if_NPC_out1 = pc + 64'd4;
            if_NPC_out2 = pc + 64'd8;
        end
        if (din1_en)
            if_IR_out1 = pc[2] ? Icache2proc_data[63:32] : Icache2proc_data[31:0];
        if (din2_en)
            if_IR_out2 = Icache2proc_data[63:32];
    end

    // PC register: redirect wins over sequential advance, and disable freezes it.
    always_ff @(posedge clk) begin
        if (reset)
            pc <= RESET_PC;
        else if (if_enable) begin
            if (ex_take_branch)
                pc <= ex_target_pc;
            else
                pc <= pc + {60'b0, n, 2'b00};
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset)
            state <= FETCH;
        else
            state <= state_nx;
    end

    // Miss tracking. The address is held by n=0, and late hit data is consumed as in FETCH.
    always_comb begin
        state_nx = state;
        if (if_enable) begin
            case (state)
                FETCH: if (!ex_take_branch && !Icache2proc_valid) state_nx = MISS;
                MISS:  if (Icache2proc_valid || ex_take_branch)   state_nx = FETCH;
                default: state_nx = FETCH;
            endcase
        end
    end

`ifdef IF_PERF_CNT_EN
    logic [31:0] fetched_q, stall_q;

    // Saturating performance counters for instructions written and non-redirect stalls.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetched_q <= 32'h0;
            stall_q   <= 32'h0;
        end else if (if_enable) begin
            if (fetched_q > 32'hFFFF_FFFF - {30'b0, n})
                fetched_q <= 32'hFFFF_FFFF;
            else
                fetched_q <= fetched_q + {30'b0, n};
            if (!ex_take_branch && n == 2'd0 && stall_q != 32'hFFFF_FFFF)
                stall_q <= stall_q + 32'd1;
        end
    end

    assign perf_fetched = fetched_q;
    assign perf_stall   = stall_q;
`else
    assign perf_fetched = 32'h0;
    assign perf_stall   = 32'h0;
`endif

endmodule

// File: tb/tb_if_fetch2.sv
// Bench for if_fetch2: directed vector table, then randomized cycles vs a reference model.

`ifndef NOOP_INST
`define NOOP_INST 32'h47ff041f
`endif

module tb_if_fetch2;

    localparam logic [31:0] NOOP = `NOOP_INST;
    localparam logic [63:0] D0   = 64'hAAAA_BBBB_CCCC_DDDD;
    localparam logic [63:0] D1   = 64'h1111_2222_3333_4444;

    logic        clk = 1'b0;
    logic        reset, if_enable, ex_take_branch, Icache2proc_valid, ifid_full, ifid_full_almost;
    logic [63:0] ex_target_pc, Icache2proc_data;
    logic [63:0] proc2Icache_addr, if_NPC_out1, if_NPC_out2;
    logic [31:0] if_IR_out1, if_IR_out2, perf_fetched, perf_stall;
    logic        if_valid_inst_out1, if_valid_inst_out2, din1_en, din2_en;

    int errors = 0;
    int checks = 0;

    // model state
    logic [63:0] mpc;
    longint      mfetched, mstall;

    always #5 clk = ~clk;

    if_fetch2 dut (
        .clk(clk), .reset(reset), .if_enable(if_enable), .ex_take_branch(ex_take_branch),
        .ex_target_pc(ex_target_pc), .Icache2proc_data(Icache2proc_data),
        .Icache2proc_valid(Icache2proc_valid), .ifid_full(ifid_full),
        .ifid_full_almost(ifid_full_almost), .proc2Icache_addr(proc2Icache_addr),
        .if_NPC_out1(if_NPC_out1), .if_NPC_out2(if_NPC_out2),
        .if_IR_out1(if_IR_out1), .if_IR_out2(if_IR_out2),
        .if_valid_inst_out1(if_valid_inst_out1), .if_valid_inst_out2(if_valid_inst_out2),
        .din1_en(din1_en), .din2_en(din2_en),
        .perf_fetched(perf_fetched), .perf_stall(perf_stall)
    );

    typedef struct {
        logic        rst, en, br;
        logic [63:0] tgt, data;
        logic        vld, full, alm;
        logic [63:0] e_addr;
        logic        e_d1, e_d2;
        logic [31:0] e_ir1, e_ir2;
        logic [63:0] e_npc1, e_npc2;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic rst, en, br, input logic [63:0] tgt, data,
                                input logic vld, full, alm, input logic [63:0] a,
                                input logic d1, d2, input logic [31:0] i1, i2,
                                input logic [63:0] n1, n2);
        vec_t v;
        v.rst = rst; v.en = en; v.br = br; v.tgt = tgt; v.data = data;
        v.vld = vld; v.full = full; v.alm = alm; v.e_addr = a;
        v.e_d1 = d1; v.e_d2 = d2; v.e_ir1 = i1; v.e_ir2 = i2; v.e_npc1 = n1; v.e_npc2 = n2;
        return v;
    endfunction

    // Reference: number of instructions the spec allows into IF/ID this cycle
    function automatic int model_n();
        if (reset || !if_enable || ex_take_branch || !Icache2proc_valid || ifid_full) return 0;
        if (ifid_full_almost || mpc[2]) return 1;
        return 2;
    endfunction

    task automatic check_perf();
`ifdef IF_PERF_CNT_EN
        chk("perf_fetched", {32'h0, perf_fetched}, mfetched > 64'hFFFF_FFFF ? 64'hFFFF_FFFF : mfetched);
        chk("perf_stall",   {32'h0, perf_stall},   mstall   > 64'hFFFF_FFFF ? 64'hFFFF_FFFF : mstall);
`else
        chk("perf_fetched", {32'h0, perf_fetched}, 64'h0);
        chk("perf_stall",   {32'h0, perf_stall},   64'h0);
`endif
    endtask

    // advance model across the coming posedge
    task automatic model_step();
        int k;
        k = model_n();
        if (reset) begin
            mpc = 64'h0; mfetched = 0; mstall = 0;
        end else if (if_enable) begin
            mfetched += k;
            if (!ex_take_branch && k == 0) mstall++;
            mpc = ex_take_branch ? ex_target_pc : mpc + 64'(4 * k);
        end
    endtask

    task automatic drive(input vec_t v);
        reset = v.rst; if_enable = v.en; ex_take_branch = v.br; ex_target_pc = v.tgt;
        Icache2proc_data = v.data; Icache2proc_valid = v.vld;
        ifid_full = v.full; ifid_full_almost = v.alm;
    endtask

    initial begin
        vec_t v;
        reset = 1; if_enable = 0; ex_take_branch = 0; ex_target_pc = 0;
        Icache2proc_data = 0; Icache2proc_valid = 0; ifid_full = 0; ifid_full_almost = 0;
        mpc = 64'h0; mfetched = 0; mstall = 0;
        repeat (2) @(posedge clk);

        //               rst en br tgt                     data vld fl al addr                    d1 d2 ir1          ir2          npc1                    npc2
        tbl.push_back(mk(1, 1, 0, 0,                      D0, 1, 0, 0, 64'h0,                  0, 0, NOOP,        NOOP,        64'h0,                  64'h0));
        tbl.push_back(mk(0, 1, 1, 64'h100,                D0, 1, 0, 0, 64'h0,                  0, 0, NOOP,        NOOP,        0, 0));
        tbl.push_back(mk(0, 1, 0, 0,                      D0, 1, 0, 0, 64'h100,                1, 1, 32'hCCCCDDDD, 32'hAAAABBBB, 64'h104, 64'h108));
        tbl.push_back(mk(0, 1, 1, 64'h114,                D0, 1, 0, 0, 64'h108,                0, 0, NOOP,        NOOP,        0, 0));
        tbl.push_back(mk(0, 1, 0, 0,                      D1, 1, 0, 0, 64'h110,                1, 0, 32'h11112222, NOOP,        64'h118, 0));
        tbl.push_back(mk(0, 1, 1, 64'h200,                D0, 1, 0, 0, 64'h118,                0, 0, NOOP,        NOOP,        0, 0));
        tbl.push_back(mk(0, 1, 0, 0,                      D0, 1, 1, 1, 64'h200,                0, 0, NOOP,        NOOP,        0, 0));
        tbl.push_back(mk(0, 1, 0, 0,                      D0, 1, 0, 1, 64'h200,                1, 0, 32'hCCCCDDDD, NOOP,        64'h204, 0));
        tbl.push_back(mk(0, 1, 1, 64'h300,                D0, 1, 0, 0, 64'h200,                0, 0, NOOP,        NOOP,        0, 0));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(0, 1, 0, 0,                  D0, 0, 0, 0, 64'h300,                0, 0, NOOP,        NOOP,        0, 0));
        tbl.push_back(mk(0, 1, 0, 0,                      D1, 1, 0, 0, 64'h300,                1, 1, 32'h33334444, 32'h11112222, 64'h304, 64'h308));
        tbl.push_back(mk(0, 1, 0, 0,                      D0, 0, 0, 0, 64'h308,                0, 0, NOOP,        NOOP,        0, 0));
        tbl.push_back(mk(0, 1, 1, 64'h4000,               D0, 0, 0, 0, 64'h308,                0, 0, NOOP,        NOOP,        0, 0));
        tbl.push_back(mk(0, 1, 0, 0,                      D0, 1, 0, 0, 64'h4000,               1, 1, 32'hCCCCDDDD, 32'hAAAABBBB, 64'h4004, 64'h4008));
        tbl.push_back(mk(0, 0, 1, 64'h8000,               D0, 1, 0, 0, 64'h4008,               0, 0, NOOP,        NOOP,        0, 0));
        tbl.push_back(mk(0, 0, 0, 0,                      D0, 1, 0, 0, 64'h4008,               0, 0, NOOP,        NOOP,        0, 0));
        tbl.push_back(mk(0, 1, 0, 0,                      D0, 1, 0, 0, 64'h4008,               1, 1, 32'hCCCCDDDD, 32'hAAAABBBB, 64'h400C, 64'h4010));
        tbl.push_back(mk(0, 1, 1, 64'hFFFF_FFFF_FFFF_FFFC, D0, 1, 0, 0, 64'h4010,              0, 0, NOOP,        NOOP,        0, 0));
        tbl.push_back(mk(0, 1, 0, 0,                      D0, 1, 0, 0, 64'hFFFF_FFFF_FFFF_FFF8, 1, 0, 32'hAAAABBBB, NOOP,       64'h0, 0));
        tbl.push_back(mk(0, 1, 0, 0,                      D0, 0, 0, 0, 64'h0,                  0, 0, NOOP,        NOOP,        0, 0));
        tbl.push_back(mk(0, 1, 0, 0,                      D0, 1, 0, 0, 64'h0,                  1, 1, 32'hCCCCDDDD, 32'hAAAABBBB, 64'h4, 64'h8));
        tbl.push_back(mk(0, 1, 0, 0,                      D0, 0, 0, 0, 64'h8,                  0, 0, NOOP,        NOOP,        0, 0));
        tbl.push_back(mk(1, 1, 0, 0,                      D0, 0, 0, 0, 64'h8,                  0, 0, NOOP,        NOOP,        64'h0, 64'h0));
        tbl.push_back(mk(0, 1, 0, 0,                      D0, 1, 0, 0, 64'h0,                  1, 1, 32'hCCCCDDDD, 32'hAAAABBBB, 64'h4, 64'h8));

        foreach (tbl[i]) begin
            @(negedge clk);
            v = tbl[i];
            drive(v);
            #1;
            chk($sformatf("v%0d addr", i), proc2Icache_addr, v.e_addr);
            chk($sformatf("v%0d din1", i), {63'h0, din1_en}, {63'h0, v.e_d1});
            chk($sformatf("v%0d din2", i), {63'h0, din2_en}, {63'h0, v.e_d2});
            chk($sformatf("v%0d val1", i), {63'h0, if_valid_inst_out1}, {63'h0, v.e_d1});
            chk($sformatf("v%0d val2", i), {63'h0, if_valid_inst_out2}, {63'h0, v.e_d2});
            chk($sformatf("v%0d ir1", i), {32'h0, if_IR_out1}, {32'h0, v.e_ir1});
            chk($sformatf("v%0d ir2", i), {32'h0, if_IR_out2}, {32'h0, v.e_ir2});
            if (v.e_d1 || v.rst) chk($sformatf("v%0d npc1", i), if_NPC_out1, v.e_npc1);
            if (v.e_d2 || v.rst) chk($sformatf("v%0d npc2", i), if_NPC_out2, v.e_npc2);
            check_perf();
            model_step();
        end

        // randomized cycles against the reference model
        for (int c = 0; c < 600; c++) begin
            int k;
            logic [31:0] w1;
            @(negedge clk);
            reset            = ($urandom_range(0, 99) < 2);
            if_enable        = ($urandom_range(0, 99) < 90);
            ex_take_branch   = ($urandom_range(0, 99) < 8);
            ex_target_pc     = ($urandom_range(0, 9) == 0) ? (64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 3) * 4))
                                                          : ({$urandom, $urandom} & ~64'h3);
            Icache2proc_data = {$urandom, $urandom};
            Icache2proc_valid= ($urandom_range(0, 99) < 75);
            ifid_full        = ($urandom_range(0, 99) < 15);
            ifid_full_almost = ($urandom_range(0, 99) < 25);
            #1;
            k  = model_n();
            w1 = Icache2proc_data[32 * mpc[2] +: 32];
            chk("rnd addr", proc2Icache_addr, mpc & ~64'h7);
            chk("rnd din1", {63'h0, din1_en}, {63'h0, k >= 1});
            chk("rnd din2", {63'h0, din2_en}, {63'h0, k == 2});
            chk("rnd ir1", {32'h0, if_IR_out1}, {32'h0, (k >= 1) ? w1 : NOOP});
            chk("rnd ir2", {32'h0, if_IR_out2}, {32'h0, (k == 2) ? Icache2proc_data[63:32] : NOOP});
            if (k >= 1) chk("rnd npc1", if_NPC_out1, mpc + 64'd4);
            if (k == 2) chk("rnd npc2", if_NPC_out2, mpc + 64'd8);
            check_perf();
            model_step();
        end

        @(negedge clk);
        #1;
        check_perf();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
